seq_divider4: RTL and testbench

SEQ_DIVIDER4 -- requirements
Module: seq_divider4

---
 rtl/seq_divider4.sv | 152 +++++++++++++++
 tb/tb_seq_divider4.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/seq_divider4.sv
// Sequential restoring divider: 8-bit dividend by 4-bit divisor, one quotient bit per clock.
// Optional macro DIV_ZERO_ERR_EN adds the err port and a fast divide-by-zero path.
module seq_divider4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] x,
  input  logic [3:0] y,
  output logic [7:0] q,
  output logic [3:0] r,
  output logic       busy,
  output logic       done
`ifdef DIV_ZERO_ERR_EN
  ,
  output logic       err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_next;

  logic [7:0] r_dvd;
  logic [7:0] w_dvd_next;
  logic [3:0] r_dvs;
  logic [3:0] w_dvs_next;
  logic [3:0] r_rem;
  logic [3:0] w_rem_next;
  logic [2:0] r_cnt;
  logic [2:0] w_cnt_next;
  logic [7:0] r_quo;
  logic [7:0] w_quo_next;
  logic [7:0] r_q;
  logic [7:0] w_q_next;
  logic [3:0] r_r;
  logic [3:0] w_r_next;
`ifdef DIV_ZERO_ERR_EN
  logic       r_err;
  logic       w_err_next;
`endif

  // A kept remainder is always below the divisor, so only 4 bits are stored;
  // the 5-bit shifted value carries the extra bit into the trial compare.
  logic [4:0] w_shift;
  logic       w_fits;
  logic [3:0] w_diff;
  logic [3:0] w_rem_step;
  logic [7:0] w_quo_step;

  assign w_shift    = {r_rem, r_dvd[7]};
  assign w_fits     = (w_shift >= {1'b0, r_dvs});
  assign w_diff     = w_shift[3:0] - r_dvs;
  assign w_rem_step = w_fits ? w_diff : w_shift[3:0];
  assign w_quo_step = {r_quo[6:0], w_fits};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_dvd   <= 8'd0;
      r_dvs   <= 4'd0;
      r_rem   <= 4'd0;
      r_cnt   <= 3'd0;
      r_quo   <= 8'd0;
      r_q     <= 8'd0;
      r_r     <= 4'd0;
`ifdef DIV_ZERO_ERR_EN
      r_err   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_dvd   <= w_dvd_next;
      r_dvs   <= w_dvs_next;
      r_rem   <= w_rem_next;
      r_cnt   <= w_cnt_next;
      r_quo   <= w_quo_next;
      r_q     <= w_q_next;
      r_r     <= w_r_next;
`ifdef DIV_ZERO_ERR_EN
      r_err   <= w_err_next;
`endif
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_dvd_next   = r_dvd;
    w_dvs_next   = r_dvs;
    w_rem_next   = r_rem;
    w_cnt_next   = r_cnt;
    w_quo_next   = r_quo;
    w_q_next     = r_q;
    w_r_next     = r_r;
`ifdef DIV_ZERO_ERR_EN
    w_err_next   = 1'b0;
`endif

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_dvd_next   = x;
          w_dvs_next   = y;
          w_rem_next   = 4'd0;
          w_cnt_next   = 3'd0;
          w_quo_next   = 8'd0;
          w_state_next = S_CALC;
`ifdef DIV_ZERO_ERR_EN
          if (y == 4'd0) begin
            w_q_next     = 8'hFF;
            w_r_next     = x[3:0];
            w_err_next   = 1'b1;
            w_state_next = S_DONE;
          end
`endif
        end
      end

      S_CALC: begin
        w_dvd_next = {r_dvd[6:0], 1'b0};
        w_rem_next = w_rem_step;
        w_quo_next = w_quo_step;
        w_cnt_next = r_cnt + 3'd1;
        if (r_cnt == 3'd7) begin
          w_q_next     = w_quo_step;
          w_r_next     = w_rem_step;
          w_state_next = S_DONE;
        end
      end

      S_DONE: begin
        w_state_next = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign q    = r_q;
  assign r    = r_r;
  assign busy = (r_state == S_CALC);
  assign done = (r_state == S_DONE);
`ifdef DIV_ZERO_ERR_EN
  assign err  = r_err;
`endif

endmodule

// File: tb/tb_seq_divider4.sv
// Randomised self-checking bench for seq_divider4 against an arithmetic x/y, x%y reference.
module tb_seq_divider4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] x_i;
  logic [3:0] y_i;
  logic [7:0] q;
  logic [3:0] r;
  logic       busy;
  logic       done;
`ifdef DIV_ZERO_ERR_EN
  logic       err;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int edge_cnt = 0;

  seq_divider4 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x     (x_i),
    .y     (y_i),
    .q     (q),
    .r     (r),
    .busy  (busy),
    .done  (done)
`ifdef DIV_ZERO_ERR_EN
    ,
    .err   (err)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  // Reference: plain integer division; a zero divisor yields all-ones and the dividend's low nibble.
  task automatic model(input logic [7:0] ax, input logic [3:0] ay,
                       output logic [7:0] eq, output logic [3:0] er);
    if (ay == 4'd0) begin
      eq = 8'hFF;
      er = ax[3:0];
    end else begin
      eq = 8'(int'(ax) / int'(ay));
      er = 4'(int'(ax) % int'(ay));
    end
  endtask

  task automatic run_op(input logic [7:0] ax, input logic [3:0] ay);
    int lat;
    int nbusy;
    logic [7:0] eq;
    logic [3:0] er;
    logic zero_fast;
    model(ax, ay, eq, er);
`ifdef DIV_ZERO_ERR_EN
    zero_fast = (ay == 4'd0);
`else
    zero_fast = 1'b0;
`endif
    @(negedge clk);
    x_i = ax;
    y_i = ay;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    nbusy = 0;
    while (!done && lat < 40) begin
      if (busy) nbusy++;
      x_i = 8'($urandom);
      y_i = 4'($urandom);
      @(negedge clk);
      lat++;
    end
    check("latency", lat, zero_fast ? 0 : 8);
    check("busy_cycles", nbusy, zero_fast ? 0 : 8);
    check("q", q, eq);
    check("r", r, er);
`ifdef DIV_ZERO_ERR_EN
    check("err", err, zero_fast);
    check("busy_in_done", busy, 0);
`endif
    $display("[TB] op x=%0d y=%0d -> q=%0d r=%0d (exp q=%0d r=%0d) lat=%0d", ax, ay, q, r, eq, er, lat);
    @(negedge clk);
    check("done_pulse_width", done, 0);
  endtask

  initial begin
    int seen_done;
    int npulse;
    int pedge [2];
    logic [7:0] pq [2];
    logic [3:0] pr [2];

    rst = 1'b1;
    start = 1'b0;
    x_i = 8'd0;
    y_i = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_q", q, 0);
    check("reset_r", r, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    $display("[TB] reset state checked");

    run_op(8'd200, 4'd7);
    run_op(8'd255, 4'd1);
    run_op(8'd5, 4'd9);
    run_op(8'hA7, 4'd0);

    // Reset arriving mid-calculation must abandon the operation silently.
    @(negedge clk);
    x_i = 8'd123;
    y_i = 4'd5;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_q", q, 0);
    check("midrst_r", r, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    seen_done = 0;
    for (int i = 0; i < 15; i++) begin
      if (done) seen_done++;
      @(negedge clk);
    end
    check("midrst_no_done", seen_done, 0);
    $display("[TB] mid-calculation reset checked, done pulses seen=%0d", seen_done);
    run_op(8'd100, 4'd10);

    // Start held high across two back-to-back operations.
    @(negedge clk);
    x_i = 8'd50;
    y_i = 4'd3;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    x_i = 8'd99;
    y_i = 4'd15;
    npulse = 0;
    pedge[0] = 0;
    pedge[1] = 0;
    pq[0] = 8'd0;
    pq[1] = 8'd0;
    pr[0] = 4'd0;
    pr[1] = 4'd0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        if (npulse < 2) begin
          pedge[npulse] = edge_cnt;
          pq[npulse] = q;
          pr[npulse] = r;
        end
        npulse++;
      end
      if (npulse == 1 && busy) start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    check("held_pulses", npulse, 2);
    check("held_spacing", pedge[1] - pedge[0], 10);
    check("held_q0", pq[0], 16);
    check("held_r0", pr[0], 2);
    check("held_q1", pq[1], 6);
    check("held_r1", pr[1], 9);
    $display("[TB] held start: pulses=%0d spacing=%0d q0=%0d r0=%0d q1=%0d r1=%0d",
             npulse, pedge[1] - pedge[0], pq[0], pr[0], pq[1], pr[1]);

    for (int i = 0; i < 500; i++) begin
      run_op(8'($urandom), 4'($urandom_range(1, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
